// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, request record and requester index for the write-back arbiter
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} wb_req_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry power-of-two buffer with push, pop, full, empty and occupancy count
module wb_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign dout = mem[rd];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(pop);
      wr <= wr + AW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates ALU and load write-backs onto the register-file write port.
// WB_RR_FAIR_EN defined: round-robin grant; undefined: load path always wins contention.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic req0_valid,
  output logic req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic req1_valid,
  output logic req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic reg_wr,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_dt,
  output logic [$clog2(DEPTH+1)-1:0] pend0,
  output logic [$clog2(DEPTH+1)-1:0] pend1
);
  import wb_pkg::*;
  localparam int W = ADDR_W + DATA_W;
  logic [W-1:0] head0, head1;
  logic full0, full1, empty0, empty1, push0, push1, pop0, pop1, gnt;
  wb_req_e sel;
  assign req0_ready = !full0 && !flush;
  assign req1_ready = !full1 && !flush;
  // writes to r0 are architecturally dead, so they are swallowed at the door
  assign push0 = req0_valid && req0_ready && req0_addr != ADDR_W'(REG_ZERO);
  assign push1 = req1_valid && req1_ready && req1_addr != ADDR_W'(REG_ZERO);
  assign gnt = (!empty0 || !empty1) && !flush;
`ifdef WB_RR_FAIR_EN
  wb_req_e last;
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= REQ_MEM;
    else if (gnt) last <= sel;
  assign sel = (!empty0 && !empty1) ? (last == REQ_ALU ? REQ_MEM : REQ_ALU)
                                    : (empty0 ? REQ_MEM : REQ_ALU);
`else
  assign sel = empty1 ? REQ_ALU : REQ_MEM;
`endif
  assign pop0 = gnt && sel == REQ_ALU;
  assign pop1 = gnt && sel == REQ_MEM;
  wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .flush(flush), .push(push0), .pop(pop0),
    .din({req0_addr, req0_data}), .dout(head0), .full(full0), .empty(empty0), .count(pend0)
  );
  wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .flush(flush), .push(push1), .pop(pop1),
    .din({req1_addr, req1_data}), .dout(head1), .full(full1), .empty(empty1), .count(pend1)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      reg_wr <= 1'b0;
      wr_reg <= '0;
      wr_dt <= '0;
    end else begin
      reg_wr <= gnt;
      if (gnt) {wr_reg, wr_dt} <= sel == REQ_MEM ? head1 : head0;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed checks of wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
  import wb_pkg::*;
  localparam int DEPTH = 2;
  localparam int PW = $clog2(DEPTH+1);
`ifdef WB_RR_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, flush, req0_valid, req1_valid, req0_ready, req1_ready, reg_wr;
  logic [ADDR_W-1:0] req0_addr, req1_addr, wr_reg;
  logic [DATA_W-1:0] req0_data, req1_data, wr_dt;
  logic [PW-1:0] pend0, pend1;
  int checks = 0;
  int failures = 0;
  wb_req_t q0[$], q1[$];
  logic m_wr;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_dt;
  int last;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_dt(wr_dt), .pend0(pend0), .pend1(pend1)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_wr = 1'b0;
    m_reg = '0;
    m_dt = '0;
    last = 1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr = '0;
    req1_addr = '0;
    req0_data = '0;
    req1_data = '0;
  endtask

  task automatic tick();
    bit r0, r1;
    int g;
    wb_req_t e;
    r0 = q0.size() < DEPTH && !flush;
    r1 = q1.size() < DEPTH && !flush;
    @(posedge clk);
    if (flush) begin
      q0.delete();
      q1.delete();
      m_wr = 1'b0;
    end else begin
      g = -1;
      if (q0.size() > 0 && q1.size() > 0) g = FAIR ? (last == 0 ? 1 : 0) : 1;
      else if (q0.size() > 0) g = 0;
      else if (q1.size() > 0) g = 1;
      m_wr = g >= 0;
      if (g >= 0) begin
        e = (g == 0) ? q0.pop_front() : q1.pop_front();
        m_reg = e.addr;
        m_dt = e.data;
        last = g;
      end
      if (req0_valid && r0 && req0_addr != '0) begin
        e.addr = req0_addr;
        e.data = req0_data;
        q0.push_back(e);
      end
      if (req1_valid && r1 && req1_addr != '0) begin
        e.addr = req1_addr;
        e.data = req1_data;
        q1.push_back(e);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({reg_wr, wr_reg, wr_dt, pend0, pend1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got reg_wr=%b wr_reg=%0d wr_dt=%h pend0=%0d pend1=%0d exp all zero",
               reg_wr, wr_reg, wr_dt, pend0, pend1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready got %b%b exp 11", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1;
    req0_addr = 5'd5;
    req0_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got %b exp 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (pend0 !== PW'(1) || reg_wr !== 1'b0) begin
      failures++;
      $display("FAIL single_edge1 got pend0=%0d reg_wr=%b exp pend0=1 reg_wr=0", pend0, reg_wr);
    end
    tick();
    checks++;
    if (reg_wr !== 1'b1 || wr_reg !== 5'd5 || wr_dt !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_write got reg_wr=%b wr_reg=%0d wr_dt=%h exp 1 5 deadbeef", reg_wr, wr_reg, wr_dt);
    end
    tick();
    checks++;
    if (reg_wr !== 1'b0 || wr_reg !== 5'd5 || wr_dt !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_hold got reg_wr=%b wr_reg=%0d wr_dt=%h exp 0 5 deadbeef", reg_wr, wr_reg, wr_dt);
    end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] seen[$];
    logic [ADDR_W-1:0] exp_order[4];
    if (FAIR) exp_order = '{5'd3, 5'd7, 5'd4, 5'd8};
    else exp_order = '{5'd7, 5'd8, 5'd3, 5'd4};
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hAA;
    tick();
    if (reg_wr) seen.push_back(wr_reg);
    req0_addr = 5'd4; req0_data = 32'h22;
    req1_addr = 5'd8; req1_data = 32'hBB;
    tick();
    if (reg_wr) seen.push_back(wr_reg);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) begin
      tick();
      if (reg_wr) seen.push_back(wr_reg);
    end
    checks++;
    if (seen.size() != 4) begin
      failures++;
      $display("FAIL contention_count got %0d exp 4", seen.size());
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== exp_order[i]) begin
        failures++;
        $display("FAIL contention_order idx=%0d got %0d exp %0d", i, seen[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit saw_full;
    bit er0, er1;
    saw_full = 1'b0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req0_valid = 1'b1; req0_addr = ADDR_W'($urandom_range(1, 31)); req0_data = $urandom;
      req1_valid = 1'b1; req1_addr = ADDR_W'($urandom_range(1, 31)); req1_data = $urandom;
      #1;
      er0 = q0.size() < DEPTH;
      er1 = q1.size() < DEPTH;
      if (!er0 || !er1) saw_full = 1'b1;
      checks++;
      if (req0_ready !== er0 || req1_ready !== er1) begin
        failures++;
        $display("FAIL bp_ready cyc=%0d got %b%b exp %b%b", c, req0_ready, req1_ready, er0, er1);
      end
      tick();
      checks++;
      if (pend0 !== PW'(q0.size()) || pend1 !== PW'(q1.size())) begin
        failures++;
        $display("FAIL bp_pend cyc=%0d got %0d/%0d exp %0d/%0d", c, pend0, pend1, q0.size(), q1.size());
      end
    end
    checks++;
    if (!saw_full) begin
      failures++;
      $display("FAIL bp_full_reached got no full buffer exp at least one");
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    do_reset();
    req0_valid = 1'b1;
    req0_addr = '0;
    req0_data = 32'h1234;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ready got %b exp 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (pend0 !== '0) begin
      failures++;
      $display("FAIL zero_pend got %0d exp 0", pend0);
    end
    repeat (3) begin
      tick();
      checks++;
      if (reg_wr !== 1'b0) begin
        failures++;
        $display("FAIL zero_wr got %b exp 0", reg_wr);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1; req0_addr = ADDR_W'(c + 1); req0_data = 32'h100 + c;
      req1_valid = 1'b1; req1_addr = ADDR_W'(c + 17); req1_data = 32'h200 + c;
      tick();
    end
    req1_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready got %b%b exp 00", req0_ready, req1_ready);
    end
    tick();
    checks++;
    if (pend0 !== '0 || pend1 !== '0 || reg_wr !== 1'b0) begin
      failures++;
      $display("FAIL flush_state got pend0=%0d pend1=%0d reg_wr=%b exp 0 0 0", pend0, pend1, reg_wr);
    end
    idle_inputs();
    tick();
    checks++;
    if (reg_wr !== 1'b0) begin
      failures++;
      $display("FAIL flush_nowrite got %b exp 0", reg_wr);
    end
  endtask

  task automatic test_async_reset();
    logic [ADDR_W-1:0] exp_first;
    exp_first = FAIR ? 5'd9 : 5'd10;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC0C0 + c;
      req1_valid = 1'b1; req1_addr = 5'd13; req1_data = 32'hD0D0 + c;
      tick();
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({reg_wr, wr_reg, wr_dt, pend0, pend1} !== '0) begin
      failures++;
      $display("FAIL async_reset got reg_wr=%b wr_reg=%0d wr_dt=%h pend0=%0d pend1=%0d exp all zero",
               reg_wr, wr_reg, wr_dt, pend0, pend1);
    end
    idle_inputs();
    model_clear();
    #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h1010;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (reg_wr !== 1'b1 || wr_reg !== exp_first) begin
      failures++;
      $display("FAIL async_first_grant got reg_wr=%b wr_reg=%0d exp 1 %0d", reg_wr, wr_reg, exp_first);
    end
    checks++;
    if (wr_reg !== m_reg || wr_dt !== m_dt) begin
      failures++;
      $display("FAIL async_model got %0d/%h exp %0d/%h", wr_reg, wr_dt, m_reg, m_dt);
    end
  endtask

  task automatic test_random();
    bit er0, er1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req0_valid = $urandom_range(0, 9) < 6;
      req1_valid = $urandom_range(0, 9) < 6;
      req0_addr = ADDR_W'($urandom_range(0, 31));
      req1_addr = ADDR_W'($urandom_range(0, 31));
      req0_data = $urandom;
      req1_data = $urandom;
      flush = $urandom_range(0, 19) == 0;
      #1;
      er0 = q0.size() < DEPTH && !flush;
      er1 = q1.size() < DEPTH && !flush;
      checks++;
      if (req0_ready !== er0 || req1_ready !== er1) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got %b%b exp %b%b", c, req0_ready, req1_ready, er0, er1);
      end
      tick();
      checks++;
      if (reg_wr !== m_wr || wr_reg !== m_reg || wr_dt !== m_dt) begin
        failures++;
        $display("FAIL rand_out cyc=%0d got %b/%0d/%h exp %b/%0d/%h", c, reg_wr, wr_reg, wr_dt, m_wr, m_reg, m_dt);
      end
      checks++;
      if (pend0 !== PW'(q0.size()) || pend1 !== PW'(q1.size())) begin
        failures++;
        $display("FAIL rand_pend cyc=%0d got %0d/%0d exp %0d/%0d", c, pend0, pend1, q0.size(), q1.size());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_zero_reg();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter for the single write port of the 32x32 register file.
- Two requesters share the port:
  - req0: ALU result path.
  - req1: load/memory return path.
- Each requester has a small FIFO buffer. Round-robin grant selects one entry per cycle.
- Drives the register file's reg_wr / wr_reg / wr_dt inputs directly from registered outputs.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- DEPTH, 2, entries per requester buffer; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of both buffers and the output stage.
- req0_valid  input  1  ALU write request valid.
- req0_ready  output  1  ALU buffer can accept.
- req0_addr  input  ADDR_W  ALU destination register.
- req0_data  input  DATA_W  ALU write data.
- req1_valid  input  1  load write request valid.
- req1_ready  output  1  load buffer can accept.
- req1_addr  input  ADDR_W  load destination register.
- req1_data  input  DATA_W  load write data.
- reg_wr  output  1  register file write enable (registered).
- wr_reg  output  ADDR_W  register file write address (registered).
- wr_dt  output  DATA_W  register file write data (registered).
- pend0  output  $clog2(DEPTH+1)  occupancy of buffer 0.
- pend1  output  $clog2(DEPTH+1)  occupancy of buffer 1.

Behaviour:
- Reset (async, rst=1):
  - Buffers empty; pend0 = pend1 = 0.
  - reg_wr = 0, wr_reg = 0, wr_dt = 0.
  - Round-robin pointer = 1, so req0 wins first contention.
  - Mid-operation reset discards all pending writes immediately.
- Accept rules:
  - Transfer on reqN_valid && reqN_ready at the rising edge.
  - reqN_ready = !full_N && !flush (combinational).
  - A request with addr == 0 is accepted (ready honoured) but discarded; it never enters the buffer and never asserts reg_wr.
- Grant (every cycle):
  - Candidates are non-empty buffers.
  - One candidate: grant it.
  - Both candidates: grant the requester not granted last.
  - The pointer updates on every grant.
- Output stage, registered:
  - On a grant at edge k, the head is popped. reg_wr = 1 with wr_reg/wr_dt = head fields during the cycle following edge k.
  - No grant: reg_wr = 0. wr_reg/wr_dt hold their last values.
- Latency: accepted at edge k, earliest reg_wr at edge k+1, visible in the cycle k+1..k+2. No input-to-output bypass.
- Throughput: one write per cycle total. Each requester gets at most 1/2 under contention.
- Simultaneous push and pop on the same buffer in one cycle: both happen; occupancy unchanged; full buffer stays full but ready is computed from pre-edge state.
- Ordering:
  - FIFO order within a requester.
  - No ordering guarantee across requesters to the same register; program-order hazards are the issue stage's responsibility.
- Flush (sync):
  - At the edge: both buffers emptied, pointer unchanged, reg_wr = 0 next cycle.
  - Flush has priority over push and grant in the same cycle.

Optional Feature:
- WB_RR_FAIR_EN
  - Defined: round-robin grant as above.
  - Undefined: fixed priority, req1 (load) always wins contention. The pointer register is not implemented.
  - All other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W constants.
  - REG_ZERO = 5'd0.
  - Typedef wb_req_t {addr, data}.
  - Enum for requester index (REQ_ALU = 0, REQ_MEM = 1).
- Sub-module wb_fifo: DEPTH-entry buffer with push, pop, full, empty and count; instantiated twice.
- Arbiter logic and output register live in wb_arbiter.

Test Plan:
- Single write: req0 addr=5 data=0xDEADBEEF accepted at edge 1 -> reg_wr=1, wr_reg=5, wr_dt=0xDEADBEEF after edge 2; reg_wr=0 after edge 3.
- Contention:
  - Stimulus: req0 pushes (3,0x11),(4,0x22) and req1 pushes (7,0xAA),(8,0xBB), same cycles.
  - With WB_RR_FAIR_EN: output order 3,7,4,8.
  - Without WB_RR_FAIR_EN: output order 7,8,3,4.
- Backpressure: hold req1_valid with 3 requests and no drain blocked (both buffers filled) -> req1_ready=0 when pend1=2; the third request is accepted only after a pop.
- Zero register: req0 addr=0 data=0x1234 -> accepted (ready=1), pend0 stays 0, reg_wr never asserted.
- Flush: buffers holding 2+2 entries, flush=1 for one cycle with req0_valid=1 -> req0_ready=0, pend0=pend1=0, reg_wr=0 the next cycle, no write issued.
- Async reset: assert rst between edges with pending entries -> pend0, pend1, reg_wr, wr_reg and wr_dt go to 0 immediately; after release, first contention grants req0.
